// File: rtl/edge_xfer_pkg.sv
// Shared types and defaults for the edge-detection transfer sequencer.
package edge_xfer_pkg;

   typedef logic [31:0] word_t;

   localparam int unsigned DEFAULT_DEPTH     = 4;
   localparam int unsigned DEFAULT_ADDR_STEP = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_WR_REQ,
      ST_WR_WAIT,
      ST_DONE
   } xfer_state_t;

   // Address arithmetic is modulo 2^32; wrap-around is intentionally silent.
   function automatic word_t xfer_addr(input word_t base, input logic [15:0] idx,
                                       input int unsigned step);
      return base + (word_t'(step) * {16'h0000, idx});
   endfunction

endpackage

// File: rtl/edge_xfer_ctrl_result_fifo.sv
// Result buffer between the edge core and the write side; pushes while full are dropped.
module result_fifo
   import edge_xfer_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
   input  logic  clk,
   input  logic  n_rst,
   input  logic  push,
   input  word_t push_data,
   input  logic  pop,
   output logic  full,
   output logic  empty,
   output word_t head
);

   // DEPTH is a power of two >= 2; one extra pointer bit separates full from empty.
   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   word_t       mem_q [DEPTH];
   word_t       mem_d [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_data;
         wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/edge_xfer_ctrl.sv
// Read/forward/write sequencer between the AHB master and the edge-detection core.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | waiting for start; results may still be pushed into the FIFO
//   ARB      | pick next transfer: write if FIFO has data, else read, else finish
//   RD_REQ   | one-cycle re pulse with the next source address
//   RD_WAIT  | hold read address until read_complete, then forward hrdata
//   WR_REQ   | one-cycle we pulse with FIFO head and next destination address
//   WR_WAIT  | hold write address/data until write_complete, then pop
//   DONE     | one-cycle done pulse
module edge_xfer_ctrl
   import edge_xfer_pkg::*;
#(
   parameter int unsigned DEPTH     = DEFAULT_DEPTH,
   parameter int unsigned ADDR_STEP = DEFAULT_ADDR_STEP
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        start,
   input  logic [31:0] src_base,
   input  logic [31:0] dst_base,
   input  logic [15:0] num_words,
   output logic        re,
   output logic        we,
   output logic [31:0] new_raddr,
   output logic [31:0] new_waddr,
   output logic [31:0] buffer2_data,
   input  logic [31:0] hrdata,
   input  logic        read_complete,
   input  logic        write_complete,
   output logic [31:0] pix_out,
   output logic        pix_valid,
   input  logic [31:0] res_in,
   input  logic        res_valid,
   output logic        busy,
   output logic        done,
   output logic        ovf_err
);

   localparam logic [15:0] DEPTH_W = 16'(DEPTH);

   xfer_state_t state_q, state_d;
   word_t       src_base_q, src_base_d;
   word_t       dst_base_q, dst_base_d;
   logic [15:0] num_words_q, num_words_d;
   logic [15:0] rd_cnt_q, rd_cnt_d;
   logic [15:0] wr_cnt_q, wr_cnt_d;
   word_t       pix_out_q, pix_out_d;
   logic        pix_valid_q, pix_valid_d;
   logic        ovf_err_q, ovf_err_d;

   logic        fifo_full;
   logic        fifo_empty;
   word_t       fifo_head;
   logic        fifo_pop;
   logic [15:0] in_flight;

   assign fifo_pop  = (state_q == ST_WR_WAIT) && write_complete;
   assign in_flight = rd_cnt_q - wr_cnt_q;

   result_fifo #(
      .DEPTH (DEPTH)
   ) u_result_fifo (
      .clk       (clk),
      .n_rst     (n_rst),
      .push      (res_valid),
      .push_data (res_in),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   always_comb begin
      state_d     = state_q;
      src_base_d  = src_base_q;
      dst_base_d  = dst_base_q;
      num_words_d = num_words_q;
      rd_cnt_d    = rd_cnt_q;
      wr_cnt_d    = wr_cnt_q;
      pix_out_d   = pix_out_q;
      pix_valid_d = 1'b0;
      ovf_err_d   = ovf_err_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               src_base_d  = src_base;
               dst_base_d  = dst_base;
               num_words_d = num_words;
               rd_cnt_d    = '0;
               wr_cnt_d    = '0;
               ovf_err_d   = 1'b0;
               state_d     = ST_ARB;
            end
         end
         ST_ARB: begin
            // Zero-length job finishes here so stale FIFO contents never get written.
            if (num_words_q == '0) begin
               state_d = ST_DONE;
            end else if (!fifo_empty) begin
               state_d = ST_WR_REQ;
            end else if ((rd_cnt_q < num_words_q) && (in_flight < DEPTH_W)) begin
               state_d = ST_RD_REQ;
            end else if (wr_cnt_q == num_words_q) begin
               state_d = ST_DONE;
            end
         end
         ST_RD_REQ: begin
            state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (read_complete) begin
               pix_out_d   = hrdata;
               pix_valid_d = 1'b1;
               rd_cnt_d    = rd_cnt_q + 16'd1;
               state_d     = ST_ARB;
            end
         end
         ST_WR_REQ: begin
            state_d = ST_WR_WAIT;
         end
         ST_WR_WAIT: begin
            if (write_complete) begin
               wr_cnt_d = wr_cnt_q + 16'd1;
               state_d  = ST_ARB;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A dropped result is flagged even in the cycle a new job is accepted.
      if (res_valid && fifo_full) begin
         ovf_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= ST_IDLE;
         src_base_q  <= '0;
         dst_base_q  <= '0;
         num_words_q <= '0;
         rd_cnt_q    <= '0;
         wr_cnt_q    <= '0;
         pix_out_q   <= '0;
         pix_valid_q <= 1'b0;
         ovf_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         src_base_q  <= src_base_d;
         dst_base_q  <= dst_base_d;
         num_words_q <= num_words_d;
         rd_cnt_q    <= rd_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         pix_out_q   <= pix_out_d;
         pix_valid_q <= pix_valid_d;
         ovf_err_q   <= ovf_err_d;
      end
   end

   // Strobes and buses decode straight from state so reset drops them without a clock.
   always_comb begin
      re           = (state_q == ST_RD_REQ);
      we           = (state_q == ST_WR_REQ);
      new_raddr    = '0;
      new_waddr    = '0;
      buffer2_data = '0;
      if ((state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT)) begin
         new_raddr = xfer_addr(src_base_q, rd_cnt_q, ADDR_STEP);
      end
      if ((state_q == ST_WR_REQ) || (state_q == ST_WR_WAIT)) begin
         new_waddr    = xfer_addr(dst_base_q, wr_cnt_q, ADDR_STEP);
         buffer2_data = fifo_head;
      end
   end

   assign pix_out   = pix_out_q;
   assign pix_valid = pix_valid_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_edge_xfer_ctrl.sv
// Directed bench for edge_xfer_ctrl: AHB responder and echo core are driven from one initial block.
module tb_edge_xfer_ctrl;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        start;
   logic [31:0] src_base;
   logic [31:0] dst_base;
   logic [15:0] num_words;
   logic        re;
   logic        we;
   logic [31:0] new_raddr;
   logic [31:0] new_waddr;
   logic [31:0] buffer2_data;
   logic [31:0] hrdata;
   logic        read_complete;
   logic        write_complete;
   logic [31:0] pix_out;
   logic        pix_valid;
   logic [31:0] res_in;
   logic        res_valid;
   logic        busy;
   logic        done;
   logic        ovf_err;

   int compared   = 0;
   int mismatched = 0;

   // Observation log written only by the monitor.
   int          cyc = 0;
   int          re_cnt = 0;
   int          we_cnt = 0;
   int          done_cnt = 0;
   int          both_cnt = 0;
   int          done_cyc = 0;
   logic [31:0] re_log [256];
   int          re_cyc [256];
   logic [31:0] we_log [256];
   logic [31:0] wd_log [256];

   int stab_err = 0;

   edge_xfer_ctrl dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .start          (start),
      .src_base       (src_base),
      .dst_base       (dst_base),
      .num_words      (num_words),
      .re             (re),
      .we             (we),
      .new_raddr      (new_raddr),
      .new_waddr      (new_waddr),
      .buffer2_data   (buffer2_data),
      .hrdata         (hrdata),
      .read_complete  (read_complete),
      .write_complete (write_complete),
      .pix_out        (pix_out),
      .pix_valid      (pix_valid),
      .res_in         (res_in),
      .res_valid      (res_valid),
      .busy           (busy),
      .done           (done),
      .ovf_err        (ovf_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (re) begin
         re_log[re_cnt] <= new_raddr;
         re_cyc[re_cnt] <= cyc + 1;
         re_cnt         <= re_cnt + 1;
      end
      if (we) begin
         we_log[we_cnt] <= new_waddr;
         wd_log[we_cnt] <= buffer2_data;
         we_cnt         <= we_cnt + 1;
      end
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc + 1;
      end
      if (re && we) begin
         both_cnt <= both_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                           output int st_cyc);
      src_base  = s;
      dst_base  = d;
      num_words = n;
      start     = 1'b1;
      step();
      start  = 1'b0;
      st_cyc = cyc;
   endtask

   // AHB responder with fixed latencies plus optional echo core and pre-loaded results.
   task automatic service(input int rd_lat, input int wr_lat, input bit echo, input int pre_n,
                          input int max_cyc, output bit got_done);
      int          rd_cd = -1;
      int          wr_cd = -1;
      int          pre_i = 0;
      logic [31:0] rd_addr = '0;
      logic [31:0] wr_addr = '0;
      logic [31:0] wr_data = '0;
      got_done = 1'b0;
      for (int c = 0; c < max_cyc; c++) begin
         read_complete  = 1'b0;
         write_complete = 1'b0;
         res_valid      = 1'b0;
         res_in         = '0;
         if (done) got_done = 1'b1;
         if (rd_cd >= 0 && new_raddr !== rd_addr) stab_err++;
         if (wr_cd >= 0 && (new_waddr !== wr_addr || buffer2_data !== wr_data)) stab_err++;
         if (rd_cd > 0) rd_cd--;
         if (rd_cd == 0) begin
            read_complete = 1'b1;
            hrdata        = rd_addr ^ 32'h5A5A_0000;
            rd_cd         = -1;
         end
         if (wr_cd > 0) wr_cd--;
         if (wr_cd == 0) begin
            write_complete = 1'b1;
            wr_cd          = -1;
         end
         if (re) begin
            rd_addr = new_raddr;
            rd_cd   = rd_lat;
         end
         if (we) begin
            wr_addr = new_waddr;
            wr_data = buffer2_data;
            wr_cd   = wr_lat;
         end
         if (pre_i < pre_n) begin
            res_valid = 1'b1;
            res_in    = 32'h11 * (pre_i + 1);
            pre_i++;
         end else if (echo && pix_valid) begin
            res_valid = 1'b1;
            res_in    = pix_out + 32'd1;
         end
         step();
         if (got_done) break;
      end
      read_complete  = 1'b0;
      write_complete = 1'b0;
      res_valid      = 1'b0;
   endtask

   initial begin
      int st;
      int rb;
      int wb;
      int db;
      bit got;

      n_rst          = 1'b0;
      start          = 1'b0;
      src_base       = '0;
      dst_base       = '0;
      num_words      = '0;
      hrdata         = '0;
      read_complete  = 1'b0;
      write_complete = 1'b0;
      res_in         = '0;
      res_valid      = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      chk("rst_re", 32'(re), 32'd0);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pix_valid", 32'(pix_valid), 32'd0);
      chk("rst_ovf", 32'(ovf_err), 32'd0);
      chk("rst_raddr", new_raddr, 32'd0);
      chk("rst_waddr", new_waddr, 32'd0);
      chk("rst_wdata", buffer2_data, 32'd0);
      chk("rst_pix_out", pix_out, 32'd0);
      n_rst = 1'b1;
      step();

      // Four-word job with echo core; a start while busy must be ignored
      rb = re_cnt; wb = we_cnt; db = done_cnt;
      do_start(32'h100, 32'h200, 16'd4, st);
      chk("t1_busy", 32'(busy), 32'd1);
      src_base  = 32'hDEAD_0000;
      num_words = 16'd9;
      start     = 1'b1;
      step();
      start = 1'b0;
      service(1, 1, 1'b1, 0, 200, got);
      chk("t1_done", 32'(got), 32'd1);
      chk("t1_done_cnt", 32'(done_cnt - db), 32'd1);
      chk("t1_re_cnt", 32'(re_cnt - rb), 32'd4);
      chk("t1_we_cnt", 32'(we_cnt - wb), 32'd4);
      chk("t1_start_to_re", 32'(re_cyc[rb] - st), 32'd2);
      chk("t1_ra0", re_log[rb],     32'h100);
      chk("t1_ra1", re_log[rb + 1], 32'h104);
      chk("t1_ra2", re_log[rb + 2], 32'h108);
      chk("t1_ra3", re_log[rb + 3], 32'h10C);
      chk("t1_wa0", we_log[wb],     32'h200);
      chk("t1_wa3", we_log[wb + 3], 32'h20C);
      chk("t1_wd0", wd_log[wb],     32'h5A5A_0101);
      chk("t1_wd3", wd_log[wb + 3], 32'h5A5A_010D);
      chk("t1_busy_end", 32'(busy), 32'd0);

      // Zero-length job
      rb = re_cnt; wb = we_cnt; db = done_cnt;
      do_start(32'h500, 32'h600, 16'd0, st);
      service(1, 1, 1'b1, 0, 20, got);
      chk("t2_done", 32'(got), 32'd1);
      chk("t2_done_lat", 32'(done_cyc - st), 32'd2);
      chk("t2_no_re", 32'(re_cnt - rb), 32'd0);
      chk("t2_no_we", 32'(we_cnt - wb), 32'd0);

      // Core withholds results: reads stop after DEPTH outstanding
      rb = re_cnt; wb = we_cnt;
      do_start(32'h1000, 32'h2000, 16'd6, st);
      service(1, 1, 1'b0, 0, 30, got);
      chk("t3_no_done", 32'(got), 32'd0);
      chk("t3_re_limit", 32'(re_cnt - rb), 32'd4);
      chk("t3_busy", 32'(busy), 32'd1);
      service(1, 1, 1'b1, 4, 200, got);
      chk("t3_done", 32'(got), 32'd1);
      chk("t3_re_total", 32'(re_cnt - rb), 32'd6);
      chk("t3_we_total", 32'(we_cnt - wb), 32'd6);
      chk("t3_ra4", re_log[rb + 4], 32'h1010);
      chk("t3_wd0", wd_log[wb], 32'h11);
      chk("t3_wa5", we_log[wb + 5], 32'h2014);

      // Slow read completion: single re pulse, address held through the wait
      rb = re_cnt;
      stab_err = 0;
      do_start(32'h7000, 32'h8000, 16'd1, st);
      service(5, 1, 1'b1, 0, 100, got);
      chk("t4_done", 32'(got), 32'd1);
      chk("t4_re_pulse", 32'(re_cnt - rb), 32'd1);
      chk("t4_ra", re_log[rb], 32'h7000);
      chk("t4_hold", 32'(stab_err), 32'd0);

      // Overflow with writes stalled
      wb = we_cnt;
      do_start(32'h3000, 32'h4000, 16'd4, st);
      service(1, 1, 1'b0, 0, 20, got);
      chk("t5_pre_ovf", 32'(ovf_err), 32'd0);
      service(1, 30, 1'b0, 5, 300, got);
      chk("t5_done", 32'(got), 32'd1);
      chk("t5_ovf", 32'(ovf_err), 32'd1);
      chk("t5_we_cnt", 32'(we_cnt - wb), 32'd4);
      chk("t5_wd3", wd_log[wb + 3], 32'h44);
      step();
      chk("t5_ovf_sticky", 32'(ovf_err), 32'd1);
      do_start(32'h0, 32'h0, 16'd0, st);
      chk("t5_ovf_clear", 32'(ovf_err), 32'd0);
      service(1, 1, 1'b0, 0, 20, got);

      // Reset during RD_WAIT, then restart
      db = done_cnt;
      do_start(32'h300, 32'h400, 16'd2, st);
      step();
      step();
      chk("t6_wait_raddr", new_raddr, 32'h300);
      #2;
      n_rst = 1'b0;
      #1;
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_re", 32'(re), 32'd0);
      chk("t6_rst_raddr", new_raddr, 32'd0);
      chk("t6_rst_pix_valid", 32'(pix_valid), 32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      step();
      chk("t6_no_done", 32'(done_cnt - db), 32'd0);
      rb = re_cnt;
      do_start(32'h300, 32'h400, 16'd2, st);
      service(1, 1, 1'b1, 0, 100, got);
      chk("t6_done", 32'(got), 32'd1);
      chk("t6_ra0", re_log[rb], 32'h300);
      chk("t6_ra1", re_log[rb + 1], 32'h304);

      chk("re_we_exclusive", 32'(both_cnt), 32'd0);
      chk("write_hold_all", 32'(stab_err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
